// File: rtl/uart_vctr_rx_if.sv
// rtl/uart_vctr_rx_if.sv - serial input, byte/vector outputs and handshake of uart_vctr_rx
// Purpose : bundles the receiver's line input, per-word outputs, vector
//           handshake and error pulses so they travel as one port.
// Signals : rx          serial line, idle high
//           vctr_ack    consumer accepts vctr_data
//           byte_data   last received word
//           byte_valid  1-cycle pulse, byte_data updated
//           vctr_data   assembled vector, word 0 in the LSB lane
//           vctr_valid  vector complete, held until acked
//           frame_err   1-cycle pulse, stop bit sampled low
//           parity_err  1-cycle pulse, parity mismatch
//           overrun     1-cycle pulse, word dropped while a vector is pending
// Modports: master = receiver side, slave = line driver / vector consumer side
interface uart_vctr_rx_if #(
   parameter int DATA_BITS = 8,
   parameter int VCTR_LEN  = 4
);
   logic                          rx;
   logic                          vctr_ack;
   logic [DATA_BITS-1:0]          byte_data;
   logic                          byte_valid;
   logic [VCTR_LEN*DATA_BITS-1:0] vctr_data;
   logic                          vctr_valid;
   logic                          frame_err;
   logic                          parity_err;
   logic                          overrun;

   modport master (
      input  rx, vctr_ack,
      output byte_data, byte_valid, vctr_data, vctr_valid,
             frame_err, parity_err, overrun
   );

   modport slave (
      output rx, vctr_ack,
      input  byte_data, byte_valid, vctr_data, vctr_valid,
             frame_err, parity_err, overrun
   );
endinterface

// File: rtl/uart_vctr_rx.sv
// rtl/uart_vctr_rx.sv - UART receiver that packs VCTR_LEN words into one handshaked vector
// Purpose : deserialises async frames on bus.rx (start, DATA_BITS LSB first,
//           optional parity, stop), reports each word, and assembles
//           VCTR_LEN consecutive good words into bus.vctr_data.
// Ports   : clock  system clock, rising edge
//           nrst   asynchronous active-low reset
//           bus    uart_vctr_rx_if.master (rx, vctr_ack in; byte/vector/error outputs)
module uart_vctr_rx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int VCTR_LEN     = 4,
   parameter int PARITY       = 0
) (
   input  logic           clock,
   input  logic           nrst,
   uart_vctr_rx_if.master bus
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BC_W  = $clog2(DATA_BITS);
   localparam int IDX_W = (VCTR_LEN > 1) ? $clog2(VCTR_LEN) : 1;

   localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT/2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VCTR_LEN - 1);
   localparam logic             ODD_PAR  = (PARITY == 2);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   state_t               state;
   logic                 rx_meta, rx_sync, rx_prev;
   logic [CNT_W-1:0]     cnt;
   logic [BC_W-1:0]      bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par;
   logic                 perr;
   logic [IDX_W-1:0]     idx;

   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         rx_meta        <= 1'b1;
         rx_sync        <= 1'b1;
         rx_prev        <= 1'b1;
         state          <= S_IDLE;
         cnt            <= '0;
         bit_cnt        <= '0;
         shreg          <= '0;
         par            <= 1'b0;
         perr           <= 1'b0;
         idx            <= '0;
         bus.byte_data  <= '0;
         bus.byte_valid <= 1'b0;
         bus.vctr_data  <= '0;
         bus.vctr_valid <= 1'b0;
         bus.frame_err  <= 1'b0;
         bus.parity_err <= 1'b0;
         bus.overrun    <= 1'b0;
      end else begin
         rx_meta <= bus.rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;

         bus.byte_valid <= 1'b0;
         bus.frame_err  <= 1'b0;
         bus.parity_err <= 1'b0;
         bus.overrun    <= 1'b0;

         // Ack retires the pending vector; a commit below in the same cycle
         // may set vctr_valid again (VCTR_LEN == 1 case).
         if (bus.vctr_valid && bus.vctr_ack)
            bus.vctr_valid <= 1'b0;

         case (state)
            S_IDLE: begin
               if (rx_prev && !rx_sync) begin
                  state <= S_START;
                  cnt   <= '0;
               end
            end

            S_START: begin
               if (cnt == HALF_M1) begin
                  cnt <= '0;
                  if (!rx_sync) begin
                     state   <= S_DATA;
                     bit_cnt <= '0;
                     par     <= 1'b0;
                     perr    <= 1'b0;
                  end else begin
                     state <= S_IDLE;     // start bit did not hold: glitch
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_DATA: begin
               if (cnt == FULL_M1) begin
                  cnt   <= '0;
                  shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
                  par   <= par ^ rx_sync;
                  if (bit_cnt == LAST_BIT)
                     state <= (PARITY != 0) ? S_PAR : S_STOP;
                  else
                     bit_cnt <= bit_cnt + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_PAR: begin
               if (cnt == FULL_M1) begin
                  cnt   <= '0;
                  // Even: data+parity ones must be even; odd: must be odd.
                  perr  <= par ^ rx_sync ^ ODD_PAR;
                  state <= S_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_STOP: begin
               if (cnt == FULL_M1) begin
                  cnt   <= '0;
                  state <= S_IDLE;
                  if (!rx_sync) begin
                     bus.frame_err <= 1'b1;
                     idx           <= '0;
                  end else if (perr) begin
                     bus.parity_err <= 1'b1;
                     idx            <= '0;
                  end else begin
                     bus.byte_data  <= shreg;
                     bus.byte_valid <= 1'b1;
                     // idx is always 0 while a vector is pending, so an ack
                     // arriving now lands the word in lane 0.
                     if (!bus.vctr_valid || bus.vctr_ack) begin
                        bus.vctr_data[idx*DATA_BITS +: DATA_BITS] <= shreg;
                        if (idx == IDX_LAST) begin
                           bus.vctr_valid <= 1'b1;
                           idx            <= '0;
                        end else begin
                           idx <= idx + 1'b1;
                        end
                     end else begin
                        bus.overrun <= 1'b1;
                     end
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_vctr_rx.sv
// tb/tb_uart_vctr_rx.sv - scoreboard bench for uart_vctr_rx (no-parity and even-parity instances)
module tb_uart_vctr_rx;
   localparam int CPB = 4;

   logic clock = 1'b0;
   logic nrst  = 1'b0;
   always #5 clock = ~clock;

   uart_vctr_rx_if #(.DATA_BITS(8), .VCTR_LEN(4)) b0 ();
   uart_vctr_rx_if #(.DATA_BITS(8), .VCTR_LEN(4)) b1 ();

   uart_vctr_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .VCTR_LEN(4), .PARITY(0)) u0 (
      .clock(clock), .nrst(nrst), .bus(b0));
   uart_vctr_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .VCTR_LEN(4), .PARITY(1)) u1 (
      .clock(clock), .nrst(nrst), .bus(b1));

   int errors = 0;
   int checks = 0;

   logic [7:0]  exp_b0[$];
   logic [31:0] exp_v0[$];
   logic [7:0]  exp_b1[$];

   int bv0 = 0, fe0 = 0, pe0 = 0, ov0 = 0;
   int bv1 = 0, fe1 = 0, pe1 = 0, ov1 = 0;
   logic vv0_prev = 1'b0;

   // Scoreboard monitors, sampled on the falling edge.
   always @(negedge clock) begin
      logic [7:0]  eb;
      logic [31:0] ev;
      if (nrst) begin
         if (b0.byte_valid) begin
            bv0++;
            checks++;
            if (exp_b0.size() == 0) begin
               errors++;
               $display("FAIL byte0_unexpected got=%h expected none", b0.byte_data);
            end else begin
               eb = exp_b0.pop_front();
               if (b0.byte_data !== eb) begin
                  errors++;
                  $display("FAIL byte0_data got=%h expected=%h", b0.byte_data, eb);
               end
            end
         end
         if (b0.vctr_valid && !vv0_prev) begin
            checks++;
            if (exp_v0.size() == 0) begin
               errors++;
               $display("FAIL vctr0_unexpected got=%h expected none", b0.vctr_data);
            end else begin
               ev = exp_v0.pop_front();
               if (b0.vctr_data !== ev) begin
                  errors++;
                  $display("FAIL vctr0_data got=%h expected=%h", b0.vctr_data, ev);
               end
            end
            checks++;
            if (b0.byte_valid !== 1'b1) begin
               errors++;
               $display("FAIL vctr0_with_byte byte_valid=%b expected=1", b0.byte_valid);
            end
         end
         vv0_prev = b0.vctr_valid;
         if (b0.frame_err)  fe0++;
         if (b0.parity_err) pe0++;
         if (b0.overrun)    ov0++;

         if (b1.byte_valid) begin
            bv1++;
            checks++;
            if (exp_b1.size() == 0) begin
               errors++;
               $display("FAIL byte1_unexpected got=%h expected none", b1.byte_data);
            end else begin
               eb = exp_b1.pop_front();
               if (b1.byte_data !== eb) begin
                  errors++;
                  $display("FAIL byte1_data got=%h expected=%h", b1.byte_data, eb);
               end
            end
         end
         if (b1.frame_err)  fe1++;
         if (b1.parity_err) pe1++;
         if (b1.overrun)    ov1++;
      end else begin
         vv0_prev = 1'b0;
      end
   end

   task automatic set_rx(input int inst, input logic v);
      if (inst == 0) b0.rx = v;
      else           b1.rx = v;
   endtask

   task automatic bit_wait();
      repeat (CPB) @(posedge clock);
      #1;
   endtask

   task automatic send_frame(input int inst, input logic [7:0] d, input bit use_par,
                             input logic pbit, input logic stop);
      @(posedge clock);
      #1;
      set_rx(inst, 1'b0);
      bit_wait();
      for (int i = 0; i < 8; i++) begin
         set_rx(inst, d[i]);
         bit_wait();
      end
      if (use_par) begin
         set_rx(inst, pbit);
         bit_wait();
      end
      set_rx(inst, stop);
      bit_wait();
      set_rx(inst, 1'b1);
      bit_wait();
   endtask

   task automatic send_good0(input logic [7:0] d);
      exp_b0.push_back(d);
      send_frame(0, d, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic do_ack0();
      @(posedge clock);
      #1;
      b0.vctr_ack = 1'b1;
      @(posedge clock);
      #1;
      b0.vctr_ack = 1'b0;
      checks++;
      if (b0.vctr_valid !== 1'b0) begin
         errors++;
         $display("FAIL ack_clears vctr_valid=%b expected=0", b0.vctr_valid);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      checks++;
      if ({b0.byte_data, b0.byte_valid, b0.vctr_data, b0.vctr_valid,
           b0.frame_err, b0.parity_err, b0.overrun} !== '0) begin
         errors++;
         $display("FAIL %s_outputs0 got bd=%h bv=%b vd=%h vv=%b fe=%b pe=%b ov=%b expected all 0",
                  tag, b0.byte_data, b0.byte_valid, b0.vctr_data, b0.vctr_valid,
                  b0.frame_err, b0.parity_err, b0.overrun);
      end
      checks++;
      if ({b1.byte_data, b1.byte_valid, b1.vctr_data, b1.vctr_valid,
           b1.frame_err, b1.parity_err, b1.overrun} !== '0) begin
         errors++;
         $display("FAIL %s_outputs1 got bd=%h bv=%b vd=%h vv=%b expected all 0",
                  tag, b1.byte_data, b1.byte_valid, b1.vctr_data, b1.vctr_valid);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      check_outputs_zero("reset");
      @(posedge clock);
      #1;
      nrst = 1'b1;
      repeat (5) @(posedge clock);
      #1;
   endtask

   task automatic test_vector();
      int b_start;
      b_start = bv0;
      exp_v0.push_back(32'h44332211);
      send_good0(8'h11);
      send_good0(8'h22);
      send_good0(8'h33);
      send_good0(8'h44);
      checks++;
      if (bv0 - b_start != 4) begin
         errors++;
         $display("FAIL vector_byte_count got=%0d expected=4", bv0 - b_start);
      end
      checks++;
      if (b0.vctr_valid !== 1'b1 || b0.vctr_data !== 32'h44332211) begin
         errors++;
         $display("FAIL vector_held got vv=%b vd=%h expected vv=1 vd=44332211",
                  b0.vctr_valid, b0.vctr_data);
      end
      do_ack0();
   endtask

   task automatic test_glitch();
      int b_start, f_start;
      b_start = bv0;
      f_start = fe0 + pe0 + ov0;
      @(posedge clock);
      #1;
      b0.rx = 1'b0;
      @(posedge clock);
      #1;
      b0.rx = 1'b1;
      repeat (12 * CPB) @(posedge clock);
      #1;
      checks++;
      if (bv0 != b_start || (fe0 + pe0 + ov0) != f_start) begin
         errors++;
         $display("FAIL glitch_ignored got bytes=%0d flags=%0d expected 0 and 0",
                  bv0 - b_start, fe0 + pe0 + ov0 - f_start);
      end
   endtask

   task automatic test_frame_err();
      int b_start, f_start;
      send_good0(8'h01);
      send_good0(8'h02);
      b_start = bv0;
      f_start = fe0;
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0);
      checks++;
      if (fe0 - f_start != 1 || bv0 != b_start) begin
         errors++;
         $display("FAIL frame_err got fe=%0d bytes=%0d expected fe=1 bytes=0",
                  fe0 - f_start, bv0 - b_start);
      end
      exp_v0.push_back(32'h40302010);
      send_good0(8'h10);
      send_good0(8'h20);
      send_good0(8'h30);
      send_good0(8'h40);
      checks++;
      if (b0.vctr_valid !== 1'b1 || b0.vctr_data !== 32'h40302010) begin
         errors++;
         $display("FAIL frame_err_fresh got vv=%b vd=%h expected vv=1 vd=40302010",
                  b0.vctr_valid, b0.vctr_data);
      end
      do_ack0();
   endtask

   task automatic test_parity();
      int b_start, p_start;
      b_start = bv1;
      p_start = pe1;
      send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
      checks++;
      if (pe1 - p_start != 1 || bv1 != b_start) begin
         errors++;
         $display("FAIL parity_bad got pe=%0d bytes=%0d expected pe=1 bytes=0",
                  pe1 - p_start, bv1 - b_start);
      end
      exp_b1.push_back(8'h03);
      send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
      checks++;
      if (pe1 - p_start != 1 || bv1 - b_start != 1) begin
         errors++;
         $display("FAIL parity_good got pe=%0d bytes=%0d expected pe=1 bytes=1",
                  pe1 - p_start, bv1 - b_start);
      end
   endtask

   task automatic test_overrun();
      int o_start;
      exp_v0.push_back(32'hA4A3A2A1);
      send_good0(8'hA1);
      send_good0(8'hA2);
      send_good0(8'hA3);
      send_good0(8'hA4);
      o_start = ov0;
      send_good0(8'h55);
      checks++;
      if (ov0 - o_start != 1) begin
         errors++;
         $display("FAIL overrun_pulse got=%0d expected=1", ov0 - o_start);
      end
      checks++;
      if (b0.vctr_valid !== 1'b1 || b0.vctr_data !== 32'hA4A3A2A1) begin
         errors++;
         $display("FAIL overrun_hold got vv=%b vd=%h expected vv=1 vd=A4A3A2A1",
                  b0.vctr_valid, b0.vctr_data);
      end
      do_ack0();
      exp_v0.push_back(32'h99887766);
      send_good0(8'h66);
      send_good0(8'h77);
      send_good0(8'h88);
      send_good0(8'h99);
      checks++;
      if (b0.vctr_data !== 32'h99887766) begin
         errors++;
         $display("FAIL overrun_lane0 got=%h expected=99887766", b0.vctr_data);
      end
      do_ack0();
   endtask

   task automatic test_reset_mid();
      send_good0(8'hC1);
      send_good0(8'hC2);
      @(posedge clock);
      #1;
      b0.rx = 1'b0;
      bit_wait();
      b0.rx = 1'b1;
      bit_wait();
      b0.rx = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      nrst = 1'b0;
      repeat (2) @(negedge clock);
      check_outputs_zero("midreset");
      #1;
      b0.rx = 1'b1;
      @(posedge clock);
      #1;
      nrst = 1'b1;
      repeat (10) @(posedge clock);
      #1;
      exp_v0.push_back(32'hD4D3D2D1);
      send_good0(8'hD1);
      send_good0(8'hD2);
      send_good0(8'hD3);
      send_good0(8'hD4);
      checks++;
      if (b0.vctr_valid !== 1'b1 || b0.vctr_data !== 32'hD4D3D2D1) begin
         errors++;
         $display("FAIL midreset_burst got vv=%b vd=%h expected vv=1 vd=D4D3D2D1",
                  b0.vctr_valid, b0.vctr_data);
      end
      do_ack0();
   endtask

   task automatic test_drain();
      repeat (4) @(posedge clock);
      #1;
      checks++;
      if (exp_b0.size() != 0 || exp_v0.size() != 0 || exp_b1.size() != 0) begin
         errors++;
         $display("FAIL drain got pending b0=%0d v0=%0d b1=%0d expected 0 0 0",
                  exp_b0.size(), exp_v0.size(), exp_b1.size());
      end
   endtask

   initial begin
      b0.rx = 1'b1;
      b1.rx = 1'b1;
      b0.vctr_ack = 1'b0;
      b1.vctr_ack = 1'b0;
      test_reset();
      test_vector();
      test_glitch();
      test_frame_err();
      test_parity();
      test_overrun();
      test_reset_mid();
      test_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
